memory_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting directly downstream of the execute stage. It consumes the execute stage's results (ALU result, zero flag, branch target, store data, destination register) plus the forwarded control bits. It performs loads and stores against the data memory through a req/ack handshake, stalling upstream while an access is outstanding. It presents registered results and the resolved branch decision to writeback and fetch.

---
 rtl/memory_stage_if.sv | 41 ++++
 rtl/memory_stage.sv | 207 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// ---------------------------------------------------------------------------
// memory_stage_if
//
// Data-memory request/acknowledge bus between the memory stage (master) and
// the data memory (slave).
//
//   req    master -> slave  access request, held until ack is seen
//   we     master -> slave  1 = write, 0 = read
//   addr   master -> slave  word address (ADDR_BITS wide)
//   wdata  master -> slave  write data
//   ack    slave -> master  access completes this cycle
//   rdata  slave -> master  read data, valid with ack on a read
// ---------------------------------------------------------------------------
interface memory_stage_if #(
    parameter int ADDR_BITS = 7
);
    logic                 req;
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          wdata;
    logic                 ack;
    logic [31:0]          rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Memory-access stage of the five-stage pipeline. Takes the execute stage
// results, performs loads/stores on the data memory over a req/ack bus,
// stalls upstream while an access is outstanding, and presents registered
// writeback results plus the resolved branch decision.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_ex_valid            execute outputs carry a valid instruction
//   i_mem_read            load
//   i_mem_write           store (wins over i_mem_read if both set)
//   i_branch, i_zero      conditional branch and ALU zero flag
//   i_reg_write           instruction writes the register file
//   i_mem_to_reg          writeback selects memory data
//   i_branch_pc           branch target
//   i_alu_result          ALU result / byte address for memory ops
//   i_data2_out           store data
//   i_dst                 destination register
//   o_stall               upstream must hold (high in every ACCESS cycle)
//   dmem                  data-memory bus (master side)
//   o_wb_*                registered writeback payload, o_wb_valid pulses
//   o_pc_src, o_pc_branch registered branch decision and target
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_ex_valid,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 i_branch,
    input  logic                 i_reg_write,
    input  logic                 i_mem_to_reg,
    input  logic [6:0]           i_branch_pc,
    input  logic                 i_zero,
    input  logic [31:0]          i_alu_result,
    input  logic [31:0]          i_data2_out,
    input  logic [4:0]           i_dst,

    output logic                 o_stall,

    memory_stage_if.master       dmem,

    output logic                 o_wb_valid,
    output logic                 o_wb_reg_write,
    output logic                 o_wb_mem_to_reg,
    output logic [31:0]          o_wb_read_data,
    output logic [31:0]          o_wb_alu_result,
    output logic [4:0]           o_wb_dst,
    output logic                 o_pc_src,
    output logic [6:0]           o_pc_branch
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic w_accept;
    logic w_isMem;

    // Bus registers
    logic                 r_dmemReq;
    logic                 r_dmemWe;
    logic [ADDR_BITS-1:0] r_dmemAddr;
    logic [31:0]          r_dmemWdata;

    // Instruction fields held while the access is outstanding
    logic        r_holdRegWrite;
    logic        r_holdMemToReg;
    logic        r_holdIsLoad;
    logic [31:0] r_holdAluResult;
    logic [4:0]  r_holdDst;

    // Writeback and branch outputs
    logic        r_wbValid;
    logic        r_wbRegWrite;
    logic        r_wbMemToReg;
    logic [31:0] r_wbReadData;
    logic [31:0] r_wbAluResult;
    logic [4:0]  r_wbDst;
    logic        r_pcSrc;
    logic [6:0]  r_pcBranch;

    // An instruction is taken only in IDLE; in ACCESS the upstream is stalled
    // and whatever it presents is ignored.
    assign w_accept = i_ex_valid && (r_state == IDLE);
    assign w_isMem  = i_mem_read || i_mem_write;
    assign o_stall  = (r_state == ACCESS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a sampled memory op opens an access, and the access
    // closes on the first cycle the memory acknowledges. Ack in IDLE has no
    // effect, which also covers a late ack after a reset.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_isMem) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem.ack) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath registers. wb_valid and pc_src default low every cycle so they
    // form single-cycle pulses; the wb payload only changes when wb_valid is
    // raised, so it holds between instructions. Bus fields stay untouched
    // through ACCESS, keeping addr/we/wdata stable until the ack edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dmemReq       <= 1'b0;
            r_dmemWe        <= 1'b0;
            r_dmemAddr      <= '0;
            r_dmemWdata     <= '0;
            r_holdRegWrite  <= 1'b0;
            r_holdMemToReg  <= 1'b0;
            r_holdIsLoad    <= 1'b0;
            r_holdAluResult <= '0;
            r_holdDst       <= '0;
            r_wbValid       <= 1'b0;
            r_wbRegWrite    <= 1'b0;
            r_wbMemToReg    <= 1'b0;
            r_wbReadData    <= '0;
            r_wbAluResult   <= '0;
            r_wbDst         <= '0;
            r_pcSrc         <= 1'b0;
            r_pcBranch      <= '0;
        end else begin
            r_wbValid <= 1'b0;
            r_pcSrc   <= 1'b0;

            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_pcSrc    <= i_branch && i_zero;
                    r_pcBranch <= i_branch_pc;

                    if (w_isMem) begin
                        r_dmemReq       <= 1'b1;
                        r_dmemWe        <= i_mem_write;
                        r_dmemAddr      <= i_alu_result[ADDR_BITS+1:2];
                        r_dmemWdata     <= i_data2_out;
                        r_holdRegWrite  <= i_reg_write;
                        r_holdMemToReg  <= i_mem_to_reg;
                        // A store with the read bit also set is a store
                        r_holdIsLoad    <= i_mem_read && !i_mem_write;
                        r_holdAluResult <= i_alu_result;
                        r_holdDst       <= i_dst;
                    end else begin
                        r_wbValid     <= 1'b1;
                        r_wbRegWrite  <= i_reg_write;
                        r_wbMemToReg  <= i_mem_to_reg;
                        r_wbReadData  <= '0;
                        r_wbAluResult <= i_alu_result;
                        r_wbDst       <= i_dst;
                    end
                end
            end else begin
                if (dmem.ack) begin
                    r_dmemReq     <= 1'b0;
                    r_wbValid     <= 1'b1;
                    r_wbRegWrite  <= r_holdRegWrite;
                    r_wbMemToReg  <= r_holdMemToReg;
                    r_wbReadData  <= r_holdIsLoad ? dmem.rdata : 32'h0;
                    r_wbAluResult <= r_holdAluResult;
                    r_wbDst       <= r_holdDst;
                end
            end
        end
    end

    assign dmem.req        = r_dmemReq;
    assign dmem.we         = r_dmemWe;
    assign dmem.addr       = r_dmemAddr;
    assign dmem.wdata      = r_dmemWdata;

    assign o_wb_valid      = r_wbValid;
    assign o_wb_reg_write  = r_wbRegWrite;
    assign o_wb_mem_to_reg = r_wbMemToReg;
    assign o_wb_read_data  = r_wbReadData;
    assign o_wb_alu_result = r_wbAluResult;
    assign o_wb_dst        = r_wbDst;
    assign o_pc_src        = r_pcSrc;
    assign o_pc_branch     = r_pcBranch;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//
// Drives directed and random instructions into memory_stage, models the data
// memory as a slave with random wait states, and checks writeback results
// against a scoreboard filled from a word-array reference model.
// ---------------------------------------------------------------------------
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        exValid;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        regWrite;
    logic        memToReg;
    logic [6:0]  branchPc;
    logic        zero;
    logic [31:0] aluResult;
    logic [31:0] data2Out;
    logic [4:0]  dst;
    logic        stall;
    logic        wbValid;
    logic        wbRegWrite;
    logic        wbMemToReg;
    logic [31:0] wbReadData;
    logic [31:0] wbAluResult;
    logic [4:0]  wbDst;
    logic        pcSrc;
    logic [6:0]  pcBranch;

    memory_stage_if #(.ADDR_BITS(7)) dmemBus ();

    memory_stage #(.ADDR_BITS(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_ex_valid      (exValid),
        .i_mem_read      (memRead),
        .i_mem_write     (memWrite),
        .i_branch        (branch),
        .i_reg_write     (regWrite),
        .i_mem_to_reg    (memToReg),
        .i_branch_pc     (branchPc),
        .i_zero          (zero),
        .i_alu_result    (aluResult),
        .i_data2_out     (data2Out),
        .i_dst           (dst),
        .o_stall         (stall),
        .dmem            (dmemBus),
        .o_wb_valid      (wbValid),
        .o_wb_reg_write  (wbRegWrite),
        .o_wb_mem_to_reg (wbMemToReg),
        .o_wb_read_data  (wbReadData),
        .o_wb_alu_result (wbAluResult),
        .o_wb_dst        (wbDst),
        .o_pc_src        (pcSrc),
        .o_pc_branch     (pcBranch)
    );

    typedef struct {
        logic        regWrite;
        logic        memToReg;
        logic [31:0] readData;
        logic [31:0] alu;
        logic [4:0]  dst;
    } wbExp_t;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } accExp_t;

    wbExp_t      expQ[$];
    accExp_t     accQ[$];
    logic [31:0] refMem[128];
    logic [31:0] slaveMem[128];

    int compared;
    int failed;
    int forceWaits;
    int lastWaits;
    bit noAck;
    bit forceAck;
    bit prevMem;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a hung handshake still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every wb_valid pulse must match the oldest expected result.
    initial begin
        wbExp_t e;
        forever begin
            @(negedge clk);
            if (wbValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious wb_valid", {63'h0, wbValid}, 64'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wb_reg_write",  {63'h0, wbRegWrite}, {63'h0, e.regWrite});
                    checkOutput("wb_mem_to_reg", {63'h0, wbMemToReg}, {63'h0, e.memToReg});
                    checkOutput("wb_read_data",  {32'h0, wbReadData}, {32'h0, e.readData});
                    checkOutput("wb_alu_result", {32'h0, wbAluResult}, {32'h0, e.alu});
                    checkOutput("wb_dst",        {59'h0, wbDst},      {59'h0, e.dst});
                end
            end
        end
    end

    // Data-memory slave: checks each new request against the expected access,
    // checks the bus stays stable while waiting, then acks after a random or
    // forced number of wait cycles.
    initial begin
        accExp_t a;
        bit      busy;
        int      waits;
        logic        curWe;
        logic [6:0]  curAddr;
        logic [31:0] curWdata;
        busy = 0;
        waits = 0;
        curWe = 0;
        curAddr = '0;
        curWdata = '0;
        dmemBus.ack = 1'b0;
        dmemBus.rdata = '0;
        forever begin
            @(negedge clk);
            if (forceAck) begin
                dmemBus.ack = 1'b1;
                dmemBus.rdata = $urandom;
                forceAck = 0;
                busy = 0;
            end else if (dmemBus.req !== 1'b1) begin
                dmemBus.ack = 1'b0;
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    if (accQ.size() == 0) begin
                        checkOutput("spurious dmem_req", {63'h0, dmemBus.req}, 64'h0);
                    end else begin
                        a = accQ.pop_front();
                        checkOutput("dmem_we",    {63'h0, dmemBus.we},    {63'h0, a.we});
                        checkOutput("dmem_addr",  {57'h0, dmemBus.addr},  {57'h0, a.addr});
                        checkOutput("dmem_wdata", {32'h0, dmemBus.wdata}, {32'h0, a.wdata});
                    end
                    curWe = dmemBus.we;
                    curAddr = dmemBus.addr;
                    curWdata = dmemBus.wdata;
                    waits = (forceWaits >= 0) ? forceWaits : int'($urandom_range(0, 3));
                    lastWaits = waits;
                end else begin
                    checkOutput("dmem hold", {24'h0, dmemBus.we, dmemBus.addr, dmemBus.wdata},
                                {24'h0, curWe, curAddr, curWdata});
                end
                if (noAck) begin
                    dmemBus.ack = 1'b0;
                end else if (waits == 0) begin
                    dmemBus.ack = 1'b1;
                    dmemBus.rdata = curWe ? $urandom : slaveMem[curAddr];
                    if (curWe) slaveMem[curAddr] = curWdata;
                    busy = 0;
                end else begin
                    dmemBus.ack = 1'b0;
                    waits--;
                end
            end
        end
    end

    // Issue one instruction from a negedge: wait out any stall (checking its
    // length against the previous access), let it be sampled, record the
    // expected results and check the branch outputs. Returns at a negedge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic br, input logic z,
                                 input logic rw, input logic m2r, input logic [6:0] bpc,
                                 input logic [31:0] alu, input logic [31:0] data, input logic [4:0] d);
        int      stallCnt;
        wbExp_t  e;
        accExp_t a;
        int      wordAddr;
        stallCnt = 0;
        exValid = 1'b1; memRead = rd; memWrite = wr; branch = br; zero = z;
        regWrite = rw; memToReg = m2r; branchPc = bpc; aluResult = alu; data2Out = data; dst = d;
        while (stall === 1'b1 && stallCnt < 64) begin
            @(negedge clk);
            stallCnt++;
        end
        checkOutput("stall cycles", 64'(stallCnt), prevMem ? 64'(lastWaits + 1) : 64'h0);
        if (stall !== 1'b0) begin
            $display("[TB] FAIL stall timeout: got stall=%0b required 0", stall);
            $fatal(1, "[TB] stall never released");
        end
        @(posedge clk);
        wordAddr = int'((alu / 4) % 128);
        e.regWrite = rw;
        e.memToReg = m2r;
        e.alu = alu;
        e.dst = d;
        e.readData = (rd && !wr) ? refMem[wordAddr] : 32'h0;
        if (wr) refMem[wordAddr] = data;
        expQ.push_back(e);
        if (rd || wr) begin
            a.we = wr;
            a.addr = 7'(wordAddr);
            a.wdata = data;
            accQ.push_back(a);
        end
        @(negedge clk);
        exValid = 1'b0;
        checkOutput("pc_src",    {63'h0, pcSrc},    {63'h0, (br && z)});
        checkOutput("pc_branch", {57'h0, pcBranch}, {57'h0, bpc});
        prevMem = rd || wr;
    endtask

    initial begin
        logic [31:0] v;
        int n;
        compared = 0; failed = 0; forceWaits = -1; lastWaits = 0;
        noAck = 0; forceAck = 0; prevMem = 0;
        rst = 1'b1; exValid = 0; memRead = 0; memWrite = 0; branch = 0; zero = 0;
        regWrite = 0; memToReg = 0; branchPc = '0; aluResult = '0; data2Out = '0; dst = '0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            refMem[i] = v;
            slaveMem[i] = v;
        end
        refMem[9] = 32'hDEAD_BEEF;
        slaveMem[9] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        checkOutput("reset stall/req/we", {61'h0, stall, dmemBus.req, dmemBus.we}, 64'h0);
        checkOutput("reset dmem addr/wdata", {dmemBus.addr, dmemBus.wdata}, 64'h0);
        checkOutput("reset wb flags", {60'h0, wbValid, wbRegWrite, wbMemToReg, pcSrc}, 64'h0);
        checkOutput("reset wb data", {wbReadData, wbAluResult}, 64'h0);
        checkOutput("reset dst/pc", {52'h0, wbDst, pcBranch}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed instructions");
        applyStimulus(0, 0, 0, 0, 1, 0, 7'h00, 32'h0000_0010, 32'h0, 5'd5);
        forceWaits = 0;
        applyStimulus(1, 0, 0, 0, 1, 1, 7'h00, 32'h0000_0024, 32'h0, 5'd3);
        forceWaits = 3;
        applyStimulus(0, 1, 0, 0, 0, 0, 7'h00, 32'h0000_0040, 32'h1234_5678, 5'd0);
        forceWaits = -1;
        applyStimulus(0, 0, 1, 1, 0, 0, 7'h2A, 32'h0000_0000, 32'h0, 5'd0);
        applyStimulus(0, 0, 1, 0, 0, 0, 7'h2A, 32'h0000_0001, 32'h0, 5'd0);
        applyStimulus(1, 1, 0, 0, 1, 1, 7'h11, 32'h0000_0050, 32'hCAFE_F00D, 5'd7);
        applyStimulus(1, 0, 0, 0, 1, 1, 7'h00, 32'h0000_0050, 32'h0, 5'd8);

        $display("[TB] random instructions");
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 7'($urandom), $urandom,
                          $urandom, 5'($urandom));
            if (!prevMem && $urandom_range(0, 3) == 0) begin
                aluResult = $urandom;
                memRead = 1'($urandom);
                @(negedge clk);
            end
        end

        n = 0;
        while (stall === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput("drain scoreboard", 64'(expQ.size()), 64'h0);
        prevMem = 0;

        $display("[TB] reset during access");
        noAck = 1;
        exValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; branch = 1'b0; zero = 1'b0;
        regWrite = 1'b1; memToReg = 1'b1; aluResult = 32'h0000_0024; data2Out = 32'h0; dst = 5'd9;
        @(posedge clk);
        accQ.push_back('{we: 1'b0, addr: 7'd9, wdata: 32'h0});
        @(negedge clk);
        exValid = 1'b0;
        checkOutput("access req/stall", {62'h0, dmemBus.req, stall}, 64'h3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        noAck = 0;
        forceAck = 1;
        checkOutput("post-reset stall/req/we", {61'h0, stall, dmemBus.req, dmemBus.we}, 64'h0);
        checkOutput("post-reset dmem addr/wdata", {dmemBus.addr, dmemBus.wdata}, 64'h0);
        checkOutput("post-reset wb flags", {60'h0, wbValid, wbRegWrite, wbMemToReg, pcSrc}, 64'h0);
        checkOutput("post-reset wb data", {wbReadData, wbAluResult}, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("late ack ignored", {61'h0, stall, dmemBus.req, wbValid}, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
